// File: rtl/dctq_block_sched.sv
// -----------------------------------------------------------------------------
// dctq_block_sched
//
// Block scheduler in front of an 8x8 DCT/quantiser core ("dctq"). It collects
// eight 64-bit pixel rows from upstream, writes them into the core's row
// buffer (addresses 0..7, all byte lanes enabled), then starts the core and
// counts the 64 coefficients it returns. While the core runs, the scheduler
// forwards downstream back-pressure to the core as a registered stall request.
//
// Optional feature (compile-time macro DCTQ_SCHED_TIMEOUT_EN):
//   A 16-bit watchdog counts non-stalled RUN cycles. When it reaches
//   TIMEOUT_CYCLES the block is aborted: err pulses for one cycle and the
//   scheduler returns to IDLE without blk_done. Without the macro no counter
//   exists, err is tied low and RUN waits indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  watchdog limit in RUN cycles (only used with the macro)
//
// Ports
//   clk         single clock, shared with the dctq core
//   reset       synchronous, active-high reset
//   row_di      upstream pixel row (8 unsigned bytes, byte 7 in [63:56])
//   row_valid   upstream row present
//   row_ready   scheduler accepts a row this cycle (IDLE/LOAD only)
//   di          row data to dctq
//   wa          row write address to dctq
//   be          byte enables to dctq
//   din_valid   write strobe to dctq
//   start       one-cycle start pulse to dctq
//   dctq_ready  dctq idle and able to start
//   dctq_valid  dctq coefficient valid
//   hold        stall request to dctq
//   out_ready   downstream can take a coefficient
//   blk_done    one-cycle pulse after the 64th coefficient
//   busy        high in every state except IDLE
//   coef_cnt    coefficients received in the current block
//   err         watchdog abort pulse
// -----------------------------------------------------------------------------
module dctq_block_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] row_di,
  input  logic        row_valid,
  output logic        row_ready,
  output logic [63:0] di,
  output logic [2:0]  wa,
  output logic [7:0]  be,
  output logic        din_valid,
  output logic        start,
  input  logic        dctq_ready,
  input  logic        dctq_valid,
  output logic        hold,
  input  logic        out_ready,
  output logic        blk_done,
  output logic        busy,
  output logic [5:0]  coef_cnt,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_RDY,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] row_cnt;     // index of the next row to be written
  logic       row_xfer;
  logic       coef_last;
  logic       tmo_hit;

  // Gated with reset so upstream never sees a handshake during the reset cycle.
  assign row_ready = ((state == S_IDLE) || (state == S_LOAD)) && !reset;
  assign row_xfer  = row_valid && row_ready;
  assign coef_last = dctq_valid && (coef_cnt == 6'd63);

`ifdef DCTQ_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Abort on the RUN cycle whose increment would make the counter reach the
  // limit. A block completing on that same cycle takes precedence.
  assign tmo_hit = (state == S_RUN) && !hold && !coef_last &&
                   (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == S_START) begin
      tmo_cnt <= '0;
    end else if ((state == S_RUN) && !hold) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign err      = tmo_hit;
  assign start    = (state == S_START);
  assign blk_done = (state == S_DONE);
  assign busy     = (state != S_IDLE);

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:     if (row_xfer) state_next = S_LOAD;
      S_LOAD:     if (row_xfer && (row_cnt == 3'd7)) state_next = S_WAIT_RDY;
      // Entered the cycle the 8th write is presented, so start can never
      // overtake that write even when dctq_ready is already high.
      S_WAIT_RDY: if (dctq_ready) state_next = S_START;
      S_START:    state_next = S_RUN;
      S_RUN: begin
        if (coef_last) begin
          state_next = S_DONE;
        end else if (tmo_hit) begin
          state_next = S_IDLE;
        end
      end
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      coef_cnt  <= '0;
      di        <= '0;
      wa        <= '0;
      be        <= '0;
      din_valid <= 1'b0;
      hold      <= 1'b0;
    end else begin
      state     <= state_next;
      din_valid <= row_xfer;

      // Write port registers keep their last values between writes.
      if (row_xfer) begin
        di      <= row_di;
        wa      <= row_cnt;
        be      <= 8'hFF;
        row_cnt <= row_cnt + 3'd1;  // wraps 7 -> 0 on the 8th row
      end

      if (state == S_START) begin
        coef_cnt <= '0;
      end else if (state == S_RUN) begin
        if (tmo_hit) begin
          coef_cnt <= '0;
        end else if (dctq_valid) begin
          coef_cnt <= coef_cnt + 6'd1;  // wraps 63 -> 0 on the last coefficient
        end
      end

      // Registered back-pressure; only meaningful while the core keeps running.
      hold <= (state == S_RUN) && (state_next == S_RUN) && !out_ready;
    end
  end

endmodule

// File: tb/tb_dctq_block_sched.sv
// -----------------------------------------------------------------------------
// tb_dctq_block_sched
//
// Self-checking bench for dctq_block_sched. Accepted rows are pushed to a
// write scoreboard when the handshake is seen; the monitor pops and compares
// every din_valid write. Coefficient counting is tracked by a small model.
// -----------------------------------------------------------------------------
module tb_dctq_block_sched;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] row_di;
  logic        row_valid;
  logic        row_ready;
  logic [63:0] di;
  logic [2:0]  wa;
  logic [7:0]  be;
  logic        din_valid;
  logic        start;
  logic        dctq_ready;
  logic        dctq_valid;
  logic        hold;
  logic        out_ready;
  logic        blk_done;
  logic        busy;
  logic [5:0]  coef_cnt;
  logic        err;

  always #5 clk = ~clk;

  dctq_block_sched #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .row_di     (row_di),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .di         (di),
    .wa         (wa),
    .be         (be),
    .din_valid  (din_valid),
    .start      (start),
    .dctq_ready (dctq_ready),
    .dctq_valid (dctq_valid),
    .hold       (hold),
    .out_ready  (out_ready),
    .blk_done   (blk_done),
    .busy       (busy),
    .coef_cnt   (coef_cnt),
    .err        (err)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  addr;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int start_cnt    = 0;
  int start_cyc    = -1;
  int done_cnt     = 0;
  int hold_cnt     = 0;
  int hold_first   = -1;
  int err_cnt      = 0;
  int err_cyc      = -1;
  int wr_first     = -1;
  int wr_last      = -1;
  int acc_cyc      = -1;
  int drop_cyc     = -1;
  int exp_coef     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: write scoreboard plus event bookkeeping.
  always @(negedge clk) begin
    if (din_valid) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_di", di, mon_e.data);
        check("wr_wa", 64'(wa), 64'(mon_e.addr));
        check("wr_be", 64'(be), 64'hFF);
        if (wa == 3'd0) wr_first = cyc;
        if (wa == 3'd7) wr_last = cyc;
      end
    end
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (blk_done) done_cnt++;
    if (hold) begin
      if (hold_cnt == 0) hold_first = cyc;
      hold_cnt++;
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input bit gapped, input logic [7:0] base);
    int  n = 0;
    int  g = 0;
    wr_t w;
    while (n < 8 && g < 200) begin
      row_valid = gapped ? (g % 3 != 1) : 1'b1;
      row_di    = row_valid ? {8{base + 8'(n)}} : 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      if (row_valid && row_ready) begin
        w.data = row_di;
        w.addr = 3'(n);
        exp_q.push_back(w);
        n++;
        acc_cyc = cyc;
      end
      step();
      g++;
    end
    row_valid = 1'b0;
    if (n < 8) check("load_rows_accepted", 64'(n), 64'd8);
  endtask

  task automatic wait_start();
    int g = 0;
    @(negedge clk);
    while (!start && g < 100) begin
      step();
      @(negedge clk);
      g++;
    end
    if (!start) check("start_timeout", 64'(start), 64'd1);
    step();
  endtask

  task automatic run_coefs(input int n_valid, input int drop_after, input int drop_len);
    int sent = 0;
    int k    = 0;
    while (sent < n_valid) begin
      out_ready  = !(k >= drop_after && k < drop_after + drop_len);
      dctq_valid = out_ready;
      if (!out_ready && k == drop_after) drop_cyc = cyc;
      @(negedge clk);
      check("coef_cnt", 64'(coef_cnt), 64'(exp_coef));
      if (dctq_valid) begin
        sent++;
        exp_coef = (exp_coef + 1) % 64;
      end
      step();
      k++;
    end
    dctq_valid = 1'b0;
    out_ready  = 1'b1;
  endtask

  task automatic finish_block(input int done_before);
    @(negedge clk);
    check("done_pulse", 64'(blk_done), 64'd1);
    check("done_coef_wrap", 64'(coef_cnt), 64'd0);
    step();
    @(negedge clk);
    check("done_busy_low", 64'(busy), 64'd0);
    check("done_row_ready", 64'(row_ready), 64'd1);
    check("done_count", 64'(done_cnt), 64'(done_before + 1));
    step();
  endtask

  task automatic check_reset_outputs();
    check("rst_di", di, 64'd0);
    check("rst_wa", 64'(wa), 64'd0);
    check("rst_be", 64'(be), 64'd0);
    check("rst_din_valid", 64'(din_valid), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_hold", 64'(hold), 64'd0);
    check("rst_blk_done", 64'(blk_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_coef_cnt", 64'(coef_cnt), 64'd0);
    check("rst_row_ready_after", 64'(row_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int done0;
    int starts0;
    int raise_cyc;

    reset      = 1'b1;
    row_valid  = 1'b0;
    row_di     = '0;
    dctq_ready = 1'b1;
    dctq_valid = 1'b0;
    out_ready  = 1'b1;

    // Reset behaviour.
    step();
    @(negedge clk);
    check("rst_row_ready_during", 64'(row_ready), 64'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    step();

    // Back-to-back rows, core already ready.
    wr_first = -1;
    wr_last  = -1;
    starts0  = start_cnt;
    load_block(1'b0, 8'h01);
    wait_start();
    check("b2b_start_latency", 64'(start_cyc - acc_cyc), 64'd2);
    check("b2b_wa_consecutive", 64'(wr_last - wr_first), 64'd7);
    check("b2b_start_once", 64'(start_cnt - starts0), 64'd1);
    done0 = done_cnt;
    run_coefs(64, 0, 0);
    finish_block(done0);
    check("b2b_no_hold", 64'(hold_cnt), 64'd0);

    // Core not ready for 20 cycles; upstream keeps offering a row meanwhile.
    dctq_ready = 1'b0;
    starts0    = start_cnt;
    load_block(1'b0, 8'h10);
    row_valid = 1'b1;
    row_di    = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0 || i == 19) check("wait_row_ready_low", 64'(row_ready), 64'd0);
      step();
    end
    row_valid  = 1'b0;
    dctq_ready = 1'b1;
    raise_cyc  = cyc;
    wait_start();
    check("wait_start_after_ready", 64'(start_cyc - raise_cyc), 64'd1);
    done0 = done_cnt;

    // Downstream drops out_ready for 5 cycles mid-block.
    hold_cnt   = 0;
    hold_first = -1;
    run_coefs(64, 20, 5);
    finish_block(done0);
    check("hold_cycles", 64'(hold_cnt), 64'd5);
    check("hold_delay", 64'(hold_first - drop_cyc), 64'd1);
    check("wait_start_once", 64'(start_cnt - starts0), 64'd1);

    // Long stall in RUN with only 10 coefficients.
    load_block(1'b0, 8'h20);
    wait_start();
    run_coefs(10, 0, 0);
    for (int i = 0; i < 150; i++) step();
`ifdef DCTQ_SCHED_TIMEOUT_EN
    check("tmo_err_once", 64'(err_cnt), 64'd1);
    check("tmo_err_cycle", 64'(err_cyc - start_cyc), 64'(TMO));
    @(negedge clk);
    check("tmo_busy_low", 64'(busy), 64'd0);
    check("tmo_coef_clear", 64'(coef_cnt), 64'd0);
    exp_coef = 0;
    step();
`else
    @(negedge clk);
    check("notmo_still_busy", 64'(busy), 64'd1);
    check("notmo_no_err", 64'(err_cnt), 64'd0);
    step();
    done0 = done_cnt;
    run_coefs(54, 0, 0);
    finish_block(done0);
`endif

    // Reset in the middle of a block.
    load_block(1'b0, 8'h30);
    wait_start();
    run_coefs(30, 0, 0);
    @(negedge clk);
    check("midrst_coef30", 64'(coef_cnt), 64'd30);
    done0 = done_cnt;
    step();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_row_ready_during", 64'(row_ready), 64'd0);
    step();
    reset = 1'b0;
    exp_coef = 0;
    @(negedge clk);
    check_reset_outputs();
    for (int i = 0; i < 3; i++) step();
    check("midrst_no_done", 64'(done_cnt), 64'(done0));

    // Next block after reset, with gapped upstream rows.
    wr_first = -1;
    wr_last  = -1;
    load_block(1'b1, 8'h40);
    wait_start();
    check("gap_wa_seen", 64'(wr_first >= 0 && wr_last > wr_first), 64'd1);
    run_coefs(64, 0, 0);
    finish_block(done0);

    for (int i = 0; i < 4; i++) step();
`ifndef DCTQ_SCHED_TIMEOUT_EN
    check("err_never", 64'(err_cnt), 64'd0);
`endif
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dctq_block_sched.md
DCTQ_BLOCK_SCHED -- requirements
Module: dctq_block_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4095: maximum cycles allowed in RUN before watchdog abort (used only with DCTQ_SCHED_TIMEOUT_EN).
REQ-002 clk  input  1  single clock for all logic; same clock drives the dctq core.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 row_di  input  64  upstream pixel row, 8 unsigned bytes, byte 7 in [63:56].
REQ-005 row_valid  input  1  upstream row present.
REQ-006 row_ready  output  1  scheduler accepts row this cycle.
REQ-007 di  output  64  row data to dctq.
REQ-008 wa  output  3  row write address to dctq.
REQ-009 be  output  8  byte enables to dctq.
REQ-010 din_valid  output  1  write strobe to dctq.
REQ-011 start  output  1  one-cycle start pulse to dctq.
REQ-012 dctq_ready  input  1  dctq idle and able to start.
REQ-013 dctq_valid  input  1  dctq coefficient valid.
REQ-014 hold  output  1  stall request to dctq.
REQ-015 out_ready  input  1  downstream can take a coefficient.
REQ-016 blk_done  output  1  one-cycle pulse after 64th coefficient.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 coef_cnt  output  6  coefficients received in current block.
REQ-019 err  output  1  watchdog abort pulse (constant 0 without DCTQ_SCHED_TIMEOUT_EN).

Function
REQ-020 FSM states: IDLE, LOAD, WAIT_RDY, START, RUN, DONE; encoding free.
REQ-021 Row handshake: transfer occurs on a cycle where row_valid and row_ready are both high; row_ready high in IDLE and LOAD only.
REQ-022 IDLE: transfer -> LOAD with row count 1; no transfer -> stay.
REQ-023 LOAD: each transfer increments 3-bit row count; transfer of 8th row (count wraps 7->0) -> WAIT_RDY.
REQ-024 For each transfer, the next cycle presents di = row_di, wa = row index 0..7, be = 8'hFF, din_valid = 1; din_valid low otherwise; di/wa/be hold their last values when din_valid is low.
REQ-025 WAIT_RDY: stays until dctq_ready = 1, then -> START; minimum one cycle in WAIT_RDY so the 8th write lands before start.
REQ-026 START: start = 1 for exactly this one cycle, coef_cnt cleared to 0; -> RUN.
REQ-027 RUN: hold = ~out_ready, registered (asserted the cycle after out_ready falls); hold = 0 in all other states.
REQ-028 RUN: each cycle with dctq_valid = 1 increments coef_cnt; the 64th (coef_cnt = 63 and dctq_valid) -> DONE, coef_cnt wraps to 0.
REQ-029 dctq_valid outside RUN is ignored; coef_cnt unchanged.
REQ-030 DONE: blk_done = 1 for one cycle; -> IDLE; row_ready rises the following cycle.
REQ-031 Simultaneous row_valid during WAIT_RDY/START/RUN/DONE: not accepted, upstream holds data.
REQ-032 Latency from 8th row acceptance to start: 2 cycles when dctq_ready already high.

Reset
REQ-033 Reset has priority over all inputs: next state IDLE; row count, coef_cnt, timeout counter = 0.
REQ-034 Reset output values: di = 0, wa = 0, be = 0, din_valid = 0, start = 0, hold = 0, blk_done = 0, busy = 0, err = 0, row_ready = 0 during the reset cycle, 1 after release.
REQ-035 Reset mid-block discards partial block; no blk_done issued.

Configuration
REQ-036 Macro DCTQ_SCHED_TIMEOUT_EN defined: 16-bit counter clears on entering RUN, increments each RUN cycle with hold = 0; reaching TIMEOUT_CYCLES -> err pulse 1 cycle, -> IDLE, no blk_done, coef_cnt cleared.
REQ-037 Macro undefined: no counter synthesized, err tied 0, RUN waits indefinitely.

Verification
REQ-038 8 rows back-to-back (row_valid constant, rows 0x0101..., 0x0202...), dctq_ready = 1 -> wa 0..7 with be = FF on consecutive cycles, start 2 cycles after 8th acceptance.
REQ-039 Gapped rows (row_valid toggling) -> only accepted rows written, wa still contiguous 0..7.
REQ-040 dctq_ready low 20 cycles after load -> start pulses exactly once, the cycle after dctq_ready rises (+1 WAIT_RDY cycle).
REQ-041 64 dctq_valid with out_ready dropped for 5 cycles mid-block -> hold high 5 cycles delayed by 1, blk_done once, coef_cnt returns to 0.
REQ-042 Reset asserted at coef_cnt = 30 -> all outputs at reset values next cycle, no blk_done, next block loads normally.
REQ-043 With DCTQ_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES = 100, only 10 dctq_valid -> err pulse at RUN cycle 100, busy low next cycle; without macro err stays 0.
